// File: rtl/bsg_flat_array_row_sequencer_if.sv
// rtl/bsg_flat_array_row_sequencer_if.sv - producer/consumer handshake bundle for the row sequencer
interface bsg_flat_array_row_sequencer_if #(
  parameter int width_p = 16,
  parameter int items_p = 10
);
  localparam int idx_w_lp = (items_p > 1) ? $clog2(items_p) : 1;

  // Producer side: whole flattened array plus emit-order select
  logic [width_p*items_p-1:0] data_i;
  logic                       v_i;
  logic                       ready_o;
  logic                       rev_i;

  // Consumer side: one row per cycle
  logic [width_p-1:0]         data_o;
  logic                       v_o;
  logic                       yumi_i;
  logic [idx_w_lp-1:0]        idx_o;
  logic                       last_o;

  modport master (
    output data_i, v_i, rev_i, yumi_i,
    input  ready_o, data_o, v_o, idx_o, last_o
  );

  modport slave (
    input  data_i, v_i, rev_i, yumi_i,
    output ready_o, data_o, v_o, idx_o, last_o
  );
endinterface

// File: rtl/bsg_flat_array_row_sequencer.sv
// rtl/bsg_flat_array_row_sequencer.sv - captures a flattened array and emits it one row per cycle
module bsg_flat_array_row_sequencer #(
  parameter int width_p = 16,
  parameter int items_p = 10
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bsg_flat_array_row_sequencer_if.slave io
);

  localparam int idx_w_lp = (items_p > 1) ? $clog2(items_p) : 1;
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(items_p - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [idx_w_lp-1:0]        idx_q, idx_d;
  logic                       rev_q, rev_d;
  logic [width_p*items_p-1:0] data_q;

  logic                       last_w;
  logic                       ready_w;
  logic                       xfer_w;
  logic [width_p-1:0]         row_w;

  // State register: reset drops any held array immediately
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rev_q   <= rev_d;
    end
  end

  // Array storage: only meaningful while SEND, so left unreset
  always_ff @(posedge clk_i) begin
    if (xfer_w) begin
      data_q <= io.data_i;
    end
  end

  // Next state: accept a new array, step the index, or finish the array
  always_comb begin
    xfer_w  = io.v_i & ready_w;
    state_d = state_q;
    idx_d   = idx_q;
    rev_d   = rev_q;
    if (xfer_w) begin
      state_d = SEND;
      rev_d   = io.rev_i;
      idx_d   = io.rev_i ? last_idx_lp : '0;
    end else if ((state_q == SEND) && io.yumi_i) begin
      if (last_w) begin
        state_d = IDLE;
      end else if (rev_q) begin
        idx_d = idx_q - 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Outputs: row select, last detection and ready (yumi_i feeds ready_o directly)
  always_comb begin
    last_w = 1'b0;
    if (state_q == SEND) begin
      last_w = rev_q ? (idx_q == '0) : (idx_q == last_idx_lp);
    end
    ready_w = (state_q == IDLE) | (last_w & io.yumi_i);

    row_w = '0;
    for (int k = 0; k < items_p; k++) begin
      if (idx_q == idx_w_lp'(k)) begin
        row_w = data_q[k*width_p +: width_p];
      end
    end

    io.ready_o = ready_w;
    io.v_o     = (state_q == SEND);
    io.last_o  = last_w;
    io.idx_o   = idx_q;
    io.data_o  = row_w;
  end

endmodule

// File: tb/tb_bsg_flat_array_row_sequencer.sv
// tb/tb_bsg_flat_array_row_sequencer.sv - randomized self-checking bench for the row sequencer
module tb_bsg_flat_array_row_sequencer;

  localparam int W = 16;
  localparam int N = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsg_flat_array_row_sequencer_if #(.width_p(W), .items_p(N)) bus ();
  bsg_flat_array_row_sequencer_if #(.width_p(8), .items_p(1)) bus1 ();

  bsg_flat_array_row_sequencer #(.width_p(W), .items_p(N)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .io     (bus)
  );

  bsg_flat_array_row_sequencer #(.width_p(8), .items_p(1)) dut1 (
    .clk_i  (clk),
    .reset_i(reset),
    .io     (bus1)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   idx;
    logic         last;
  } row_t;

  typedef struct packed {
    logic         ready;
    logic         v;
    logic [W-1:0] d;
    logic [3:0]   idx;
    logic         last;
  } obs_t;

  // Reference model: the rows still owed to the consumer, in emit order
  row_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W*N-1:0] arr_a;

  // Queue every row of an accepted array in the order the consumer must see them
  task automatic model_accept(input logic [W*N-1:0] d, input logic rev);
    row_t r;
    for (int k = 0; k < N; k++) begin
      int i;
      i      = rev ? (N - 1 - k) : k;
      r.d    = d[i*W +: W];
      r.idx  = 4'(i);
      r.last = (k == N - 1);
      exp_q.push_back(r);
    end
  endtask

  // Drive one cycle, return observed and modelled outputs (row fields zeroed when not valid)
  task automatic step(input logic v, input logic [W*N-1:0] d, input logic rev, input logic yumi,
                      output obs_t got, output obs_t exp);
    logic exp_ready;
    @(negedge clk);
    bus.v_i    = v;
    bus.data_i = d;
    bus.rev_i  = rev;
    bus.yumi_i = yumi;
    #1;
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && yumi);
    exp       = '0;
    exp.ready = exp_ready;
    exp.v     = (exp_q.size() != 0);
    if (exp.v) begin
      exp.d    = exp_q[0].d;
      exp.idx  = exp_q[0].idx;
      exp.last = exp_q[0].last;
    end
    got       = '0;
    got.ready = bus.ready_o;
    got.v     = bus.v_o;
    if (exp.v) begin
      got.d    = bus.data_o;
      got.idx  = bus.idx_o;
      got.last = bus.last_o;
    end
    if (exp.v && yumi) void'(exp_q.pop_front());
    if (v && exp_ready) model_accept(d, rev);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.v_i     = 1'b0;
    bus.data_i  = '0;
    bus.rev_i   = 1'b0;
    bus.yumi_i  = 1'b0;
    bus1.v_i    = 1'b0;
    bus1.data_i = '0;
    bus1.rev_i  = 1'b0;
    bus1.yumi_i = 1'b0;
    #1;
    tests_run++;
    if ({bus.v_o, bus.ready_o, bus.last_o, bus.idx_o} !== 7'b0100000) begin
      tests_failed++;
      $display("FAIL reset_state: got v/rdy/last/idx=%b%b%b/%h expected 010/0",
               bus.v_o, bus.ready_o, bus.last_o, bus.idx_o);
    end
    tests_run++;
    if ({bus1.v_o, bus1.ready_o, bus1.last_o} !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_state_n1: got v/rdy/last=%b%b%b expected 010", bus1.v_o, bus1.ready_o, bus1.last_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_forward();
    obs_t got, exp;
    for (int c = 0; c < 13; c++) begin
      step(c == 0, arr_a, 1'b0, 1'b1, got, exp);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL fwd_drain cyc %0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_reverse();
    obs_t got, exp;
    for (int c = 0; c < 13; c++) begin
      step(c == 0, arr_a, 1'b1, 1'b1, got, exp);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL rev_drain cyc %0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t got, exp;
    logic [W*N-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 34; c++) begin
      step(c == 0, d, 1'b0, ((c % 3) == 0), got, exp);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL backpressure cyc %0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    logic [W*N-1:0] y;
    y = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 24; c++) begin
      if (c == 0)       step(1'b1, arr_a, 1'b0, 1'b1, got, exp);
      else if (c <= 10) step(1'b1, y, 1'b1, 1'b1, got, exp);
      else              step(1'b0, '0, 1'b0, 1'b1, got, exp);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    logic [W*N-1:0] d;
    for (int c = 0; c < 5; c++) begin
      step(c == 0, arr_a, 1'b0, c != 0, got, exp);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reset_mid_pre cyc %0d: got %h expected %h", c, got, exp);
      end
    end
    @(negedge clk);
    bus.yumi_i = 1'b0;
    #1;
    tests_run++;
    if ({bus.v_o, bus.idx_o, bus.data_o} !== {1'b1, 4'd4, 16'hA004}) begin
      tests_failed++;
      $display("FAIL reset_mid_at4: got v/idx/data=%b/%h/%h expected 1/4/a004", bus.v_o, bus.idx_o, bus.data_o);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.v_o, bus.ready_o, bus.last_o} !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got v/rdy/last=%b%b%b expected 010", bus.v_o, bus.ready_o, bus.last_o);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 13; c++) begin
      step(c == 0, d, 1'b0, 1'b1, got, exp);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reset_mid_post cyc %0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_single_item();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      bus1.v_i    = 1'b1;
      bus1.data_i = 8'h5A;
      bus1.rev_i  = r[0];
      bus1.yumi_i = 1'b0;
      #1;
      tests_run++;
      if ({bus1.ready_o, bus1.v_o} !== 2'b10) begin
        tests_failed++;
        $display("FAIL n1_accept rev %0d: got rdy/v=%b%b expected 10", r, bus1.ready_o, bus1.v_o);
      end
      @(negedge clk);
      bus1.v_i    = 1'b0;
      bus1.data_i = 8'h00;
      bus1.yumi_i = 1'b1;
      #1;
      tests_run++;
      if ({bus1.v_o, bus1.data_o, bus1.last_o, bus1.idx_o, bus1.ready_o} !== {1'b1, 8'h5A, 1'b1, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL n1_row rev %0d: got v/data/last/idx/rdy=%b/%h/%b/%b/%b expected 1/5a/1/0/1",
                 r, bus1.v_o, bus1.data_o, bus1.last_o, bus1.idx_o, bus1.ready_o);
      end
      @(negedge clk);
      bus1.yumi_i = 1'b0;
      #1;
      tests_run++;
      if ({bus1.v_o, bus1.last_o} !== 2'b00) begin
        tests_failed++;
        $display("FAIL n1_done rev %0d: got v/last=%b%b expected 00", r, bus1.v_o, bus1.last_o);
      end
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    logic [W*N-1:0] d;
    for (int c = 0; c < 400; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (c < 360) step($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, got, exp);
      else         step(1'b0, d, 1'b0, 1'b1, got, exp);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random cyc %0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) arr_a[k*W +: W] = 16'hA000 + 16'(k);
    test_reset();
    test_forward();
    test_reverse();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_single_item();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsg_flat_array_row_sequencer.md
BSG_FLAT_ARRAY_ROW_SEQUENCER -- requirements
Module: bsg_flat_array_row_sequencer

Interface
REQ-001 SHALL have parameter width_p, default 16: bits per row.
REQ-002 SHALL have parameter items_p, default 10: rows per flattened array; legal range 1..256.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port data_i, input, width_p*items_p: flattened array; row k occupies bits [k*width_p +: width_p].
REQ-006 SHALL have port v_i, input, 1: data_i valid.
REQ-007 SHALL have port ready_o, output, 1: block accepts data_i this cycle; transfer occurs when v_i & ready_o.
REQ-008 SHALL have port rev_i, input, 1: emit order select, sampled only on transfer; 0 = row 0 first, 1 = row items_p-1 first.
REQ-009 SHALL have port data_o, output, width_p: current row.
REQ-010 SHALL have port v_o, output, 1: data_o valid.
REQ-011 SHALL have port yumi_i, input, 1: consumer takes data_o this cycle; legal only while v_o=1.
REQ-012 SHALL have port idx_o, output, max(1,$clog2(items_p)): array index of the row on data_o.
REQ-013 SHALL have port last_o, output, 1: the row on data_o is the final row of the current array.

Function
REQ-014 SHALL implement two states: IDLE (no array held) and SEND (array held, rows pending).
REQ-015 SHALL register the full data_i and rev_i on transfer; data_o SHALL come from this register, never from data_i directly.
REQ-016 On transfer, SHALL go to SEND and load idx to 0 (rev=0) or items_p-1 (rev=1).
REQ-017 In SEND, v_o SHALL be 1; data_o SHALL equal stored row idx_o; in IDLE v_o=0 and data_o, idx_o, last_o are don't-care.
REQ-018 On yumi_i in SEND and not last, SHALL step idx by +1 (rev=0) or -1 (rev=1) the next cycle.
REQ-019 last_o SHALL be 1 in SEND when idx_o = items_p-1 (rev=0) or 0 (rev=1); last_o SHALL be 0 in IDLE.
REQ-020 On yumi_i with last_o=1: if v_i=1 the new array SHALL be transferred in the same cycle and SEND continues with the new array's first row the next cycle; otherwise the state SHALL return to IDLE.
REQ-021 ready_o SHALL equal (state==IDLE) | (last_o & yumi_i); combinational yumi_i->ready_o path permitted.
REQ-022 Without yumi_i, data_o, idx_o and last_o SHALL hold stable in SEND.
REQ-023 Latency: first row SHALL appear on data_o exactly 1 cycle after transfer; sustained throughput exactly 1 row/cycle, including across array boundaries (no bubble) when v_i is held.
REQ-024 items_p=1: every row SHALL be last_o=1, idx_o=0, and rev_i SHALL have no effect.
REQ-025 idx arithmetic SHALL never wrap: index never leaves 0..items_p-1.
REQ-026 yumi_i while v_o=0 is illegal; the block SHALL ignore it (no state change).

Reset
REQ-027 Assertion of reset_i SHALL immediately force IDLE, v_o=0, last_o=0, ready_o=1 (once yumi_i is 0), idx=0, stored rev=0, independent of clk_i.
REQ-028 Reset mid-array SHALL discard all remaining rows; no partial-array rows SHALL be emitted after deassertion.
REQ-029 Stored data register is not reset; no output depends on it while v_o=0.

Verification
REQ-030 Forward drain: defaults, data_i row k = 16'hA000+k, rev_i=0, yumi_i held 1 -> data_o A000..A009 on 10 consecutive cycles starting 1 cycle after transfer, idx_o 0..9, last_o only at idx 9, then v_o=0.
REQ-031 Reverse drain: same data, rev_i=1 -> data_o A009..A000, idx_o 9..0, last_o only with A000.
REQ-032 Back-pressure: yumi_i toggled 1,0,0,1,... -> each row held stable while yumi_i=0, no row skipped or duplicated, 10 rows total.
REQ-033 Back-to-back: v_i held 1 with arrays X (rev 0) and Y (rev 1), yumi_i=1 -> 20 consecutive valid rows, ready_o=1 only in the X-last cycle, Y emitted in reverse with no bubble.
REQ-034 Reset at idx_o=4 -> v_o=0 immediately, ready_o=1; next transfer starts at idx 0 with new data.
REQ-035 items_p=1, width_p=8, data_i=8'h5A -> one cycle v_o=1, data_o=5A, last_o=1, idx_o=0, for both rev_i values.
